// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the data-memory arbitration slice.
package rv_mem_pkg;

  localparam int IO_BIT_DEF = 22;
  localparam int MASK_W     = 4;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Command captured at grant time and replayed for the whole access.
  typedef struct packed {
    logic                  we;
    logic [MASK_W-1:0]     wmask;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Address bit IO_BIT steers the access to the IO driver instead of RAM.
  function automatic logic addr_is_io(input logic [CMD_ADDR_W-1:0] addr, input int io_bit);
    return addr[io_bit];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not served last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // Combinational winner selection.
  always_comb begin
    grant = 1'b0;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = 1'b0;
        valid = 1'b1;
      end
      2'b10: begin
        grant = 1'b1;
        valid = 1'b1;
      end
      2'b11: begin
        grant = ~last_grant;
        valid = 1'b1;
      end
      default: begin
        grant = 1'b0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory / IO resource between the core port (0) and a
// loader/debug port (1). Each access runs IDLE -> ACCESS (-> RESP for reads).
module dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IO_BIT = IO_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [3:0]        wmask0_i,
  input  logic [3:0]        wmask1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              io_we_o,
  input  logic [DATA_W-1:0] io_rdata_i,
  output logic              busy_o,
  output logic              grant_o
);

  arb_state_t state_r, state_s;
  mem_cmd_t   cmd_r, cmd_s;
  logic       is_io_r, is_io_s;
  logic       grant_r, grant_s;
  logic       last_grant_r, last_grant_s;
  logic       pick_grant_s, pick_valid_s;

  rr_arbiter2 u_rr (
    .req        (req_i),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .valid      (pick_valid_s)
  );

  // State and latched command; asserting reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cmd_r        <= '0;
      is_io_r      <= 1'b0;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      cmd_r        <= cmd_s;
      is_io_r      <= is_io_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Next state: latch the winner's command in IDLE, record fairness on completion.
  always_comb begin
    state_s      = state_r;
    cmd_s        = cmd_r;
    is_io_s      = is_io_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_s = pick_grant_s;
          if (pick_grant_s) begin
            cmd_s = '{we: we_i[1], wmask: wmask1_i,
                      addr: CMD_ADDR_W'(addr1_i), wdata: CMD_DATA_W'(wdata1_i)};
          end else begin
            cmd_s = '{we: we_i[0], wmask: wmask0_i,
                      addr: CMD_ADDR_W'(addr0_i), wdata: CMD_DATA_W'(wdata0_i)};
          end
          is_io_s = addr_is_io(cmd_s.addr, IO_BIT);
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cmd_r.we) begin
          last_grant_s = grant_r;
          state_s      = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      RESP: begin
        last_grant_s = grant_r;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Strobes and completion decoded from the registered state; a read never writes.
  always_comb begin
    done_o      = 2'b00;
    mem_wmask_o = 4'h0;
    io_we_o     = 1'b0;
    rdata_o     = {DATA_W{1'b0}};
    case (state_r)
      ACCESS: begin
        if (cmd_r.we) begin
          done_o = grant_r ? 2'b10 : 2'b01;
          if (is_io_r) begin
            io_we_o = 1'b1;
          end else begin
            mem_wmask_o = cmd_r.wmask;
          end
        end else begin
          done_o = 2'b00;
        end
      end
      RESP: begin
        done_o  = grant_r ? 2'b10 : 2'b01;
        rdata_o = is_io_r ? io_rdata_i : mem_rdata_i;
      end
      default: begin
        done_o = 2'b00;
      end
    endcase
  end

  assign mem_addr_o  = ADDR_W'(cmd_r.addr);
  assign mem_wdata_o = DATA_W'(cmd_r.wdata);
  assign busy_o      = (state_r != IDLE);
  assign grant_o     = grant_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-timeline reference model
// plus a small RAM/IO environment with synchronous read data.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_i, we_i;
  logic [3:0]  wmask0_i, wmask1_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [1:0]  done_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i, io_rdata_i;
  logic [3:0]  mem_wmask_o;
  logic        io_we_o, busy_o, grant_o;
  logic        env_init;
  logic [31:0] env_ram [16];
  logic [31:0] env_io  [16];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
    .wmask0_i(wmask0_i), .wmask1_i(wmask1_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .done_o(done_o), .rdata_o(rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i), .io_we_o(io_we_o), .io_rdata_i(io_rdata_i),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  function automatic logic [31:0] init_ram(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] init_io(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Environment memories: byte-masked RAM and word-wide IO, read data one cycle late.
  always_ff @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) begin
        env_ram[i] <= init_ram(i);
        env_io[i]  <= init_io(i);
      end
      mem_rdata_i <= 32'h0;
      io_rdata_i  <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b]) env_ram[mem_addr_o[5:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      if (io_we_o) env_io[mem_addr_o[5:2]] <= mem_wdata_o;
      mem_rdata_i <= env_ram[mem_addr_o[5:2]];
      io_rdata_i  <= env_io[mem_addr_o[5:2]];
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          start;
  } tcmd_t;

  tcmd_t       q0[$], q1[$];
  int          grant_log[$];
  int          cyc, n_checks, n_errors;
  logic [31:0] ref_ram [16];
  logic [31:0] ref_io  [16];
  bit          out_valid;
  int          out_port, grant_cyc, done_cyc, next_free, m_last;
  logic        out_we, out_io, m_grant;
  logic [3:0]  out_wmask;
  logic [31:0] out_rdata, m_addr, m_wdata;
  int          rst_at;
  bit          rst_armed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_done",  32'(done_o),      32'h0);
    chk("rst_rdata", rdata_o,          32'h0);
    chk("rst_addr",  mem_addr_o,       32'h0);
    chk("rst_wdata", mem_wdata_o,      32'h0);
    chk("rst_wmask", 32'(mem_wmask_o), 32'h0);
    chk("rst_io_we", 32'(io_we_o),     32'h0);
    chk("rst_busy",  32'(busy_o),      32'h0);
    chk("rst_grant", 32'(grant_o),     32'h0);
  endtask

  task automatic model_reset(input int free_at);
    out_valid = 1'b0;
    m_last    = 1;
    m_grant   = 1'b0;
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    next_free = free_at;
  endtask

  task automatic check_cycle();
    logic       act, ei;
    logic [1:0] ed;
    logic [3:0] ew;
    act = out_valid && cyc > grant_cyc && cyc <= done_cyc;
    ed  = (out_valid && cyc == done_cyc) ? ((out_port == 1) ? 2'b10 : 2'b01) : 2'b00;
    ew  = (out_valid && out_we && !out_io && cyc == grant_cyc + 1) ? out_wmask : 4'h0;
    ei  = out_valid && out_we && out_io && cyc == grant_cyc + 1;
    chk("done",  32'(done_o),      32'(ed));
    chk("wmask", 32'(mem_wmask_o), 32'(ew));
    chk("io_we", 32'(io_we_o),     32'(ei));
    chk("busy",  32'(busy_o),      32'(act));
    chk("grant", 32'(grant_o),     32'(m_grant));
    chk("addr",  mem_addr_o,       m_addr);
    chk("wdata", mem_wdata_o,      m_wdata);
    if (ed != 2'b00 && !out_we) chk("rdata", rdata_o, out_rdata);
  endtask

  // Retire, drive the requesters for this cycle, and arbitrate when free.
  task automatic drive_cycle();
    bit    p0, p1;
    int    w;
    tcmd_t c;
    if (out_valid && done_cyc == cyc - 1) begin
      if (out_port == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      out_valid = 1'b0;
    end
    p0 = q0.size() > 0 && q0[0].start <= cyc;
    p1 = q1.size() > 0 && q1[0].start <= cyc;
    req_i = {p1, p0};
    we_i = 2'b00; wmask0_i = 4'h0; wmask1_i = 4'h0;
    addr0_i = 32'h0; addr1_i = 32'h0; wdata0_i = 32'h0; wdata1_i = 32'h0;
    if (p0) begin
      we_i[0] = q0[0].we; wmask0_i = q0[0].wmask; addr0_i = q0[0].addr; wdata0_i = q0[0].wdata;
    end
    if (p1) begin
      we_i[1] = q1[0].we; wmask1_i = q1[0].wmask; addr1_i = q1[0].addr; wdata1_i = q1[0].wdata;
    end
    if (cyc >= next_free && (p0 || p1)) begin
      if (p0 && p1) w = 1 - m_last;
      else w = p0 ? 0 : 1;
      c = (w == 0) ? q0[0] : q1[0];
      out_valid = 1'b1; out_port = w; out_we = c.we; out_io = c.addr[22];
      out_wmask = c.wmask; grant_cyc = cyc; done_cyc = cyc + (c.we ? 1 : 2);
      next_free = done_cyc + 1; m_last = w; m_grant = (w == 1);
      m_addr = c.addr; m_wdata = c.wdata;
      if (c.we) begin
        if (out_io) ref_io[c.addr[5:2]] = c.wdata;
        else for (int b = 0; b < 4; b++)
          if (c.wmask[b]) ref_ram[c.addr[5:2]][8*b +: 8] = c.wdata[8*b +: 8];
      end else begin
        out_rdata = out_io ? ref_io[c.addr[5:2]] : ref_ram[c.addr[5:2]];
      end
      grant_log.push_back(w);
      if (rst_armed && w == 1 && !c.we) begin
        rst_at    = cyc + 2;
        rst_armed = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == rst_at) begin
      reset = 1'b0;
      #1;
      check_reset_outputs();
      model_reset(cyc + 1);
      drive_cycle();
    end else begin
      if (cyc == rst_at + 1) reset = 1'b1;
      check_cycle();
      drive_cycle();
    end
  endtask

  task automatic run_until_idle();
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < next_free) && guard < 4000) begin
      step();
      guard++;
    end
    chk("drain", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  task automatic push(input int port, input logic we, input logic [3:0] wm,
                      input logic [31:0] addr, input logic [31:0] wd, input int start);
    tcmd_t c;
    c.we = we; c.wmask = wm; c.addr = addr; c.wdata = wd; c.start = start;
    if (port == 0) q0.push_back(c);
    else q1.push_back(c);
  endtask

  function automatic logic [31:0] rand_addr();
    logic       io;
    logic [3:0] idx;
    logic [1:0] lo;
    io  = ($urandom_range(0, 3) == 0);
    idx = 4'($urandom_range(0, 15));
    lo  = 2'($urandom_range(0, 3));
    return {9'b0, io, 16'b0, idx, lo};
  endfunction

  initial begin
    reset = 1'b0; env_init = 1'b1; req_i = 2'b00; we_i = 2'b00;
    wmask0_i = 4'h0; wmask1_i = 4'h0; addr0_i = 32'h0; addr1_i = 32'h0;
    wdata0_i = 32'h0; wdata1_i = 32'h0;
    cyc = 0; n_checks = 0; n_errors = 0; rst_at = -10; rst_armed = 1'b0;
    grant_cyc = 0; done_cyc = 0; out_port = 0; out_we = 1'b0; out_io = 1'b0;
    out_wmask = 4'h0; out_rdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      ref_ram[i] = init_ram(i);
      ref_io[i]  = init_io(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    env_init = 1'b0;
    reset    = 1'b1;
    model_reset(0);

    // Both ports read from reset: port 0 first, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 4'h0, {26'h0, 4'(i), 2'b00}, 32'h0, 0);
      push(1, 1'b0, 4'h0, {26'h0, 4'(i + 8), 2'b00}, 32'h0, 0);
    end
    drive_cycle();
    run_until_idle();
    for (int i = 0; i < 8; i++) chk("alternate", 32'(grant_log[i]), 32'(i % 2));

    // Port-0 read of RAM word holding DEADBEEF.
    push(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, cyc + 1);
    run_until_idle();

    // Port-1 full-word IO write.
    push(1, 1'b1, 4'hF, 32'h0040_0000, 32'h0000_001F, cyc + 1);
    run_until_idle();

    // Read carrying a write mask must not write.
    push(0, 1'b0, 4'hF, 32'h0000_0014, 32'hFFFF_FFFF, cyc + 1);
    run_until_idle();

    // Reset during RESP of a port-1 read; the request then completes afresh.
    rst_armed = 1'b1;
    push(1, 1'b0, 4'h0, 32'h0040_0008, 32'h0, cyc + 1);
    run_until_idle();

    // Byte write then read-back of the merged word.
    push(0, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AB_0000, cyc + 1);
    push(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, cyc + 1);
    run_until_idle();
    chk("byte_merge", ref_ram[8], {init_ram(8)[31:24], 8'hAB, init_ram(8)[15:0]});

    // Random traffic on both ports with overlapping request windows.
    for (int i = 0; i < 120; i++) begin
      push(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(),
           $urandom, cyc + i * 3 + $urandom_range(0, 4));
      push(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(),
           $urandom, cyc + i * 3 + $urandom_range(0, 4));
    end
    run_until_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
